// File: rtl/decomp_pkg.sv
package decomp_pkg;

  localparam int unsigned DEF_INPUT_WORD = 32;
  localparam int unsigned DEF_DICT_ENTRY = 16;

  typedef enum logic [1:0] {
    MT_LITERAL = 2'b00,
    MT_MATCH2  = 2'b01,
    MT_MATCH3  = 2'b10,
    MT_FULL    = 2'b11
  } match_type_e;

endpackage

// File: rtl/decomp_dictionary.sv
// Shift dictionary with per-entry valid bits; entry 0 is the newest word.
module decomp_dictionary
  import decomp_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_INPUT_WORD,
  parameter int unsigned DEPTH = DEF_DICT_ENTRY,
  parameter int unsigned LOC_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_word,
  input  logic [LOC_W-1:0] location,
  output logic [WIDTH-1:0] rd_word,
  output logic             rd_valid
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data[k] <= '0;
      end
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (push) begin
      data[0] <= push_word;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        data[k] <= data[k-1];
      end
      valid <= {valid[DEPTH-2:0], 1'b1};
    end
  end

  // Unfilled entries read as zero.
  always_comb begin
    rd_valid = valid[location];
    rd_word  = rd_valid ? data[location] : '0;
  end

endmodule

// File: rtl/word_decompressor.sv
// Rebuilds 32-bit words from decoded match codes against a shift dictionary.
module word_decompressor
  import decomp_pkg::*;
#(
  parameter int unsigned INPUT_WORD = DEF_INPUT_WORD,
  parameter int unsigned DICT_ENTRY = DEF_DICT_ENTRY,
  parameter int unsigned LOC_W      = $clog2(DICT_ENTRY)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_type,
  input  logic                  i_align,
  input  logic [LOC_W-1:0]      i_location,
  input  logic [INPUT_WORD-1:0] i_literal,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INPUT_WORD-1:0] o_word,
  output logic [15:0]           o_count,
  output logic                  o_error
);

  match_type_e           mtype;
  logic                  accept;
  logic [INPUT_WORD-1:0] dict_word;
  logic                  dict_valid;
  logic [INPUT_WORD-1:0] rebuilt;

  assign mtype   = match_type_e'(i_type);
  assign o_ready = !i_clear && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;

  decomp_dictionary #(
    .WIDTH (INPUT_WORD),
    .DEPTH (DICT_ENTRY),
    .LOC_W (LOC_W)
  ) u_dict (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (i_clear),
    .push      (accept && (mtype != MT_FULL)),
    .push_word (rebuilt),
    .location  (i_location),
    .rd_word   (dict_word),
    .rd_valid  (dict_valid)
  );

  always_comb begin
    rebuilt = '0;
    case (mtype)
      MT_LITERAL: rebuilt = i_literal;
      MT_MATCH2:  rebuilt = i_align ? {i_literal[15:0], dict_word[INPUT_WORD-17:0]}
                                    : {dict_word[INPUT_WORD-1:16], i_literal[15:0]};
      MT_MATCH3:  rebuilt = i_align ? {i_literal[7:0], dict_word[INPUT_WORD-9:0]}
                                    : {dict_word[INPUT_WORD-1:8], i_literal[7:0]};
      MT_FULL:    rebuilt = dict_word;
      default:    rebuilt = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_word  <= '0;
      o_count <= '0;
      o_error <= 1'b0;
    end else begin
      if (accept) begin
        o_valid <= 1'b1;
        o_word  <= rebuilt;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end

      if (i_clear) begin
        o_count <= '0;
      end else if (o_valid && i_ready) begin
        o_count <= o_count + 16'd1;
      end

      if (i_clear) begin
        o_error <= 1'b0;
      end else if (accept && (mtype != MT_LITERAL) && !dict_valid) begin
        o_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_decompressor.sv
module tb_word_decompressor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic        ready_out;
  logic [1:0]  typ = 2'b00;
  logic        align = 1'b0;
  logic [3:0]  loc = 4'd0;
  logic [31:0] literal = '0;
  logic        ovalid;
  logic        dready = 1'b0;
  logic [31:0] word;
  logic [15:0] count;
  logic        error;

  word_decompressor #(.INPUT_WORD(32), .DICT_ENTRY(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (clear),
    .i_valid    (valid),
    .o_ready    (ready_out),
    .i_type     (typ),
    .i_align    (align),
    .i_location (loc),
    .i_literal  (literal),
    .o_valid    (ovalid),
    .i_ready    (dready),
    .o_word     (word),
    .o_count    (count),
    .o_error    (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb [$];

  // reference model state
  logic [31:0] mdict [16];
  bit          mval  [16];
  bit          m_ovalid;
  int          m_count;
  bit          m_err;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mdict[i] = '0;
      mval[i]  = 1'b0;
    end
    m_ovalid = 1'b0;
    m_count  = 0;
    m_err    = 1'b0;
    sb.delete();
  endfunction

  function automatic logic [31:0] model_word(int t, bit al, int l, logic [31:0] lit);
    logic [31:0] d;
    d = mval[l] ? mdict[l] : 32'd0;
    case (t)
      0: return lit;
      1: return al ? ((lit << 16) | (d & 32'h0000_FFFF)) : ((d & 32'hFFFF_0000) | (lit & 32'h0000_FFFF));
      2: return al ? ((lit << 24) | (d & 32'h00FF_FFFF)) : ((d & 32'hFFFF_FF00) | (lit & 32'h0000_00FF));
      default: return d;
    endcase
  endfunction

  task automatic step(input bit v, input int t, input bit al, input int l,
                      input logic [31:0] lit, input bit rdy, input bit clr);
    bit          m_ready;
    bit          acc;
    logic [31:0] w;
    @(negedge clk);
    check("count", {16'd0, count}, m_count[15:0]);
    check("error", {31'd0, error}, {31'd0, m_err});
    check("o_valid", {31'd0, ovalid}, {31'd0, m_ovalid});
    valid   = v;
    typ     = 2'(t);
    align   = al;
    loc     = 4'(l);
    literal = lit;
    dready  = rdy;
    clear   = clr;
    #1;
    m_ready = !clr && (!m_ovalid || rdy);
    check("o_ready", {31'd0, ready_out}, {31'd0, m_ready});
    acc = v && m_ready;
    if (clr) begin
      for (int i = 0; i < 16; i++) mval[i] = 1'b0;
      m_count = 0;
      m_err   = 1'b0;
    end else if (m_ovalid && rdy) begin
      m_count = (m_count + 1) % 65536;
    end
    if (acc) begin
      if (t != 0 && !mval[l]) m_err = 1'b1;
      w = model_word(t, al, l, lit);
      sb.push_back(w);
      if (t != 3) begin
        for (int i = 15; i > 0; i--) begin
          mdict[i] = mdict[i-1];
          mval[i]  = mval[i-1];
        end
        mdict[0] = w;
        mval[0]  = 1'b1;
      end
    end
    m_ovalid = acc ? 1'b1 : (rdy ? 1'b0 : m_ovalid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    dready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_o_word", word, 32'd0);
    check("rst_o_ready", {31'd0, ready_out}, 32'd1);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  // monitor: compares the presented word against the scoreboard head, pops on handshake
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && ovalid) begin
        if (sb.size() == 0) begin
          check("unexpected_word", word, 32'hFFFF_FFFF ^ word);
        end else begin
          check("o_word", word, sb[0]);
          if (dready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();

    // 1: literal then full match of it
    step(1, 0, 0, 0, 32'hDEAD_BEEF, 1, 0);
    step(1, 3, 0, 0, 32'h0, 1, 0);
    drain();
    check("t1_count", {16'd0, count}, 32'd2);
    check("t1_error", {31'd0, error}, 32'd0);

    // 2: partial matches, both alignments
    step(1, 0, 0, 0, 32'h1234_5678, 1, 0);
    step(1, 1, 0, 0, 32'h0000_AAAA, 1, 0);
    step(1, 2, 1, 1, 32'h0000_00CC, 1, 0);
    drain();

    // 3: 17 literals, oldest dropped, full match at deepest entry
    for (int i = 1; i <= 17; i++) step(1, 0, 0, 0, i, 1, 0);
    step(1, 3, 0, 15, 0, 1, 0);
    step(1, 3, 0, 15, 0, 1, 0);
    drain();

    // 4: downstream stall with pending input
    step(1, 0, 0, 0, 32'hCAFE_0001, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'hBAD0_0000 + i, 0, 0);
    step(1, 3, 0, 0, 0, 1, 0);
    drain();

    // 5: unfilled entry after reset, sticky error, clear
    do_reset();
    step(1, 3, 0, 5, 0, 1, 0);
    drain();
    check("t5_error_set", {31'd0, error}, 32'd1);
    step(0, 0, 0, 0, 0, 1, 1);
    drain();

    // 6: clear wins over a valid beat
    step(1, 0, 0, 0, 32'h5555_AAAA, 1, 0);
    step(1, 0, 0, 0, 32'h7777_7777, 0, 1);
    step(1, 3, 0, 0, 0, 1, 0);
    drain();
    check("t6_error_set", {31'd0, error}, 32'd1);

    // random traffic with occasional clear and reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 400) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 60) == 0);
    end
    drain();
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
